instr_fetch_stage: RTL
======================

# instr_fetch_stage

- Front stage of the RISC datapath: holds the program counter and fetches 8-bit instructions from instruction memory over a req/ack handshake.
- Presents the fetched instruction to the control unit as a 2-bit opcode plus a 6-bit operand field.
- Redirects the PC when the control unit asserts `branch` for the instruction being consumed.
- Sits directly upstream of the control unit and the register-file read stage.

## Interface

Parameters:

- `PC_WIDTH`, 6: program counter / instruction memory address width; must be ≤ 6.
- `RESET_PC`, 0: PC value loaded on reset.

Ports:

- `clk`  input  1  sole clock; all state updates on rising edge.
- `rst_n`  input  1  reset, synchronous, active-low.
- `imem_req`  output  1  fetch request; held until `imem_ack`.
- `imem_addr`  output  PC_WIDTH  fetch address; stable while `imem_req`=1.
- `imem_rdata`  input  8  instruction word; valid when `imem_ack`=1.
- `imem_ack`  input  1  memory completion strobe.
- `stall`  input  1  downstream hold; instruction is not consumed while high.
- `branch`  input  1  from control unit; meaningful only in the consume cycle.
- `instr_valid`  output  1  `opcode`/`operand` hold a valid instruction.
- `opcode`  output  2  `instr[7:6]`, feeds the control unit.
- `operand`  output  6  `instr[5:0]`; also the absolute branch target.
- `pc_out`  output  PC_WIDTH  address of the instruction currently presented.
- `halted`  output  1  halt indication; see Configuration.

## Operation

- Instruction register `instr[7:0]` and PC register `pc`.
- FSM states: IDLE, FETCH, VALID, HALT (HALT only with macro).
  - **IDLE:** entered on reset; next cycle → FETCH unconditionally.
  - **FETCH:** `imem_req`=1, `imem_addr`=`pc`. On `imem_ack`=1: `instr`<=`imem_rdata`, → VALID. Otherwise stay.
  - **VALID:** `instr_valid`=1. Consume condition is `stall`=0.
    - On consume with `branch`=1: `pc`<=`operand[PC_WIDTH-1:0]`.
    - On consume with `branch`=0: `pc`<=`pc`+1, modulo 2^PC_WIDTH, so wrap from max to 0.
    - After consume, → FETCH.
    - While `stall`=1: all outputs and `pc` hold; `branch` is ignored.
- `branch` is sampled only in VALID with `stall`=0. A branch to self (target == `pc`) is legal and refetches the same address.
- `imem_ack` outside FETCH is ignored; `imem_rdata` is not captured.
- `pc_out` = `pc`, which is the address of the presented instruction since `pc` only advances on consume.
- Reset values: `imem_req`=0, `imem_addr`=RESET_PC, `instr_valid`=0, `opcode`=0, `operand`=0, `pc_out`=RESET_PC, `halted`=0, `instr`=0.
- Reset mid-fetch: `rst_n`=0 on an edge overrides everything, including a coincident `imem_ack`. The in-flight response is dropped, and the bench must not return a stale ack after reset.

## Timing

- Request issue: first FETCH cycle is the 2nd edge after `rst_n` deasserts (IDLE occupies one cycle).
- Fetch latency: ack in FETCH cycle N → `instr_valid`=1 in cycle N+1. A zero-wait memory (ack in same cycle as req) is supported.
- Best-case throughput is one instruction per 2 cycles (FETCH, VALID); each memory wait cycle adds one.
- Consume in cycle M → new `pc` and `imem_req`=1 with the new `imem_addr` in cycle M+1.
- `imem_addr` and `imem_req` are registered-state decodes with no combinational path from `imem_ack`.
- The only combinational input→output loop allowed is outside this block: `opcode` → control unit → `branch`. The block never drives outputs from `branch` in the same cycle.

## Configuration

- Macro `IFETCH_HALT_EN`.
- **Defined:**
  - Consuming instruction 8'h00 (opcode 00, operand 0) moves the FSM to HALT and leaves `pc` unchanged.
  - In HALT: `imem_req`=0, `instr_valid`=0, `halted`=1. HALT exits only via reset.
- **Undefined:**
  - 8'h00 is an ordinary instruction and `pc` increments.
  - `halted` is tied to 0 and no HALT state exists.

## Test plan

- Reset with RESET_PC=0, zero-wait memory, program 8'h40,8'h41,8'h80 → addresses 0,1,2 requested on cycles 2,4,6; `opcode` sequence 01,01,10; `instr_valid` high on cycles 3,5,7.
- `imem_ack` delayed 3 cycles → `imem_req` and `imem_addr` stable for 4 cycles; `instr_valid` rises the cycle after ack.
- `stall`=1 for 5 cycles in VALID with `branch` toggling → outputs, `pc`, `opcode` unchanged; no request issued; the consume after `stall` drops uses the `branch` value from that cycle only.
- Instruction 8'hC5 at pc=3, `branch`=1 on consume → next `imem_addr`=5. Branch to self (8'hC3 at 3) → address 3 refetched. Sequential at pc=63 → next address 0.
- `rst_n`=0 asserted in FETCH coincident with `imem_ack` → instruction not captured; all outputs at reset values next cycle; refetch from RESET_PC.
- With `IFETCH_HALT_EN`: consume 8'h00 at pc=4 → `halted`=1, `imem_req`=0 thereafter, `pc_out`=4. Without the macro: next address 5, `halted`=0.

Source files
------------

// File: rtl/instr_fetch_stage.sv
// Instruction fetch stage: owns the PC, fetches 8-bit instructions over req/ack
// and presents opcode/operand downstream. Optional HALT on 8'h00 via IFETCH_HALT_EN.
module instr_fetch_stage #(
    parameter int                  PC_WIDTH = 6,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                rst_n,
    output logic                imem_req,
    output logic [PC_WIDTH-1:0] imem_addr,
    input  logic [7:0]          imem_rdata,
    input  logic                imem_ack,
    input  logic                stall,
    input  logic                branch,
    output logic                instr_valid,
    output logic [1:0]          opcode,
    output logic [5:0]          operand,
    output logic [PC_WIDTH-1:0] pc_out,
    output logic                halted,
    output logic [1:0]          dbg_state
);

    // Handshakes: a fetch completes on a cycle with imem_req && imem_ack (req is held
    // until then); an instruction is consumed on a cycle with instr_valid && !stall.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_VALID = 2'd2
`ifdef IFETCH_HALT_EN
        ,
        S_HALT  = 2'd3
`endif
    } state_e;

    localparam logic [PC_WIDTH-1:0] PC_ONE = 1;

    state_e              state_q, state_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic [7:0]          instr_q, instr_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            instr_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        case (state_q)
            S_IDLE: begin
                state_d = S_FETCH;
            end
            S_FETCH: begin
                if (imem_ack) begin
                    instr_d = imem_rdata;
                    state_d = S_VALID;
                end
            end
            S_VALID: begin
                // branch is only looked at in the consume cycle
                if (!stall) begin
`ifdef IFETCH_HALT_EN
                    if (instr_q == 8'h00) begin
                        state_d = S_HALT;
                    end else
`endif
                    begin
                        state_d = S_FETCH;
                        if (branch) begin
                            pc_d = instr_q[PC_WIDTH-1:0];
                        end else begin
                            pc_d = pc_q + PC_ONE;
                        end
                    end
                end
            end
`ifdef IFETCH_HALT_EN
            S_HALT: begin
                state_d = S_HALT;
            end
`endif
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // All outputs decode registered state only; nothing depends on ack or branch.
    assign imem_req    = (state_q == S_FETCH);
    assign imem_addr   = pc_q;
    assign instr_valid = (state_q == S_VALID);
    assign opcode      = instr_q[7:6];
    assign operand     = instr_q[5:0];
    assign pc_out      = pc_q;
    assign dbg_state   = state_q;
`ifdef IFETCH_HALT_EN
    assign halted      = (state_q == S_HALT);
`else
    assign halted      = 1'b0;
`endif

endmodule
